synaptic_current_accumulator: RTL and testbench
===============================================

Name: synaptic_current_accumulator

Overview:
Parametrised, time-multiplexed successor to the single-cycle synaptic input-current summer. It captures a spike vector and a packed signed weight vector on a start handshake, then accumulates LANES synapses per cycle. It saturates the sum to a signed OUT_W result and pulses done. It sits between the spike-delay/routing stage and the LIF neuron membrane update, and trades latency for adder area.

Parameters:
M, 24, number of synaptic inputs (>=1)
W, 8, signed weight width in bits
LANES, 4, synapses summed per cycle (1..M; M need not be a multiple)
OUT_W, 8, signed output current width (<= ACC_W)
Derived localparams: C = ceil(M/LANES) accumulate cycles; ACC_W = W + clog2(M) + 1 signed accumulator width (never overflows).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a new accumulation; sampled only in IDLE
input_spikes  input  M  spike bits; bit i gates weight i
weights  input  M*W  packed signed weights; weight i = weights[i*W +: W]
busy  output  1  high while accumulating
done  output  1  one-cycle pulse when input_current is updated
input_current  output  OUT_W  saturated signed sum, held until the next done
saturated  output  1  high if the latest result was clamped; updated with done

Behaviour:
- Reset (async, any state): state=IDLE; acc=0; idx=0; busy=0; done=0; input_current=0; saturated=0; shadow registers=0.
- FSM states: IDLE, ACCUM.
- IDLE + start=1 at edge E0:
  - Copy input_spikes and weights into shadow registers.
  - acc<=0, idx<=0, busy<=1, state<=ACCUM.
- ACCUM, each edge:
  - acc_next = acc + sum over j<LANES of (shadow_spike[idx+j] ? sext(shadow_w[idx+j]) : 0).
  - Indices >= M contribute 0.
  - idx<=idx+LANES.
- Final ACCUM edge (idx+LANES >= M), i.e. edge E0+C:
  - input_current<=sat(acc_next); saturated<=clamp flag; done<=1; busy<=0; state<=IDLE.
- Saturation: if acc_next > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1. If acc_next < -2^(OUT_W-1), output -2^(OUT_W-1). Otherwise output the low OUT_W bits. saturated=1 only when clamped.
- Latency: done is high during the cycle after edge E0+C, i.e. exactly C cycles after the start edge. done is deasserted on the next edge unless another completion occurs.
- Input changes: input_spikes and weights changes after E0 have no effect on the running result.
- start while busy: ignored, not queued.
- start in the cycle done is high: accepted (state is IDLE). This gives back-to-back operation with throughput of one result per C+1 cycles.
- start held high continuously: a new accumulation begins on every IDLE cycle.
- Reset mid-ACCUM: the operation is aborted; no done pulse; outputs go to reset values.
- M=LANES: C=1, so done follows start by one cycle.

Optional Feature:
Macro SYN_BIAS_EN.
- Defined:
  - Adds input port bias (W bits, signed), sampled into a shadow register at start.
  - acc is initialised to sext(bias) instead of 0.
  - Saturation applies after the bias is included.
  - ACC_W grows by 1.
- Undefined: no bias port; acc starts at 0. Behaviour is otherwise identical.

Test Plan (M=24, W=8, LANES=4, OUT_W=8, C=6):
1. start with spikes=0, arbitrary weights -> busy high for 6 cycles; done pulses 6 cycles after start; input_current=0; saturated=0.
2. spikes bits 0,1,5 with weights 10,20,-5 (others 0x7F, unspiked) -> input_current=25 (0x19); saturated=0.
3. all 24 spikes, all weights 100 -> sum 2400 -> input_current=127 (0x7F); saturated=1. Then all weights -128 -> sum -3072 -> 0x80; saturated=1.
4. start, then change spikes/weights and toggle start every cycle while busy -> result matches values captured at start; only one done; next start accepted in the done cycle; second done 7 cycles after the first.
5. assert reset 3 cycles into ACCUM -> busy=0, done never pulses, input_current=0, saturated=0. A following start yields the correct full result.
6. SYN_BIAS_EN defined, bias=-30, spikes bits 2,3 with weights 50,40 -> 60. Same with bias=127, spikes bit 0 weight 1 -> 127 clamped; saturated=1.

Source files
------------

// File: rtl/synaptic_current_accumulator_if.sv
// synaptic_current_accumulator_if: start/operand/result bundle between the routing stage (master) and the accumulator (slave); bias exists only when SYN_BIAS_EN is defined
interface synaptic_current_accumulator_if #(
  parameter int M = 24,
  parameter int W = 8,
  parameter int OUT_W = 8
);
  logic start;
  logic [M-1:0] input_spikes;
  logic [M*W-1:0] weights;
`ifdef SYN_BIAS_EN
  logic [W-1:0] bias;
`endif
  logic busy;
  logic done;
  logic [OUT_W-1:0] input_current;
  logic saturated;
`ifdef SYN_BIAS_EN
  modport master(output start, input_spikes, weights, bias, input busy, done, input_current, saturated);
  modport slave(input start, input_spikes, weights, bias, output busy, done, input_current, saturated);
`else
  modport master(output start, input_spikes, weights, input busy, done, input_current, saturated);
  modport slave(input start, input_spikes, weights, output busy, done, input_current, saturated);
`endif
endinterface

// File: rtl/synaptic_current_accumulator.sv
// synaptic_current_accumulator: time-multiplexed saturating sum of spike-gated signed weights, LANES per cycle (clk, async reset, bus: start/input_spikes/weights[/bias] in, busy/done/input_current/saturated out; SYN_BIAS_EN adds bias)
module synaptic_current_accumulator #(
  parameter int M = 24,
  parameter int W = 8,
  parameter int LANES = 4,
  parameter int OUT_W = 8
)(
  input logic clk,
  input logic reset,
  synaptic_current_accumulator_if.slave bus
);
`ifdef SYN_BIAS_EN
  localparam int ACC_W = W + $clog2(M) + 2;
`else
  localparam int ACC_W = W + $clog2(M) + 1;
`endif
  localparam int IDX_W = $clog2(M + LANES + 1);
  localparam logic signed [ACC_W-1:0] MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MIN = ~MAX;
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_next;
  logic [M-1:0] sp;
  logic [M*W-1:0] sw;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic [IDX_W-1:0] idx;
  logic last, hi, lo;
  // shadows shift down by LANES each cycle so the current group always sits in lanes 0..LANES-1 and spent slots fill with zeros
  always_comb begin
    acc_next = acc;
    for (int j = 0; j < LANES; j++)
      acc_next = acc_next + (sp[j] ? ACC_W'($signed(sw[j*W +: W])) : '0);
  end
  assign last = idx + IDX_W'(LANES) >= IDX_W'(M);
  assign hi = acc_next > MAX;
  assign lo = acc_next < MIN;
  always_comb state_next = state == IDLE ? (bus.start ? ACCUM : IDLE) : (last ? IDLE : ACCUM);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      idx <= '0;
      sp <= '0;
      sw <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.input_current <= '0;
      bus.saturated <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          sp <= bus.input_spikes;
          sw <= bus.weights;
`ifdef SYN_BIAS_EN
          acc <= ACC_W'($signed(bus.bias));
`else
          acc <= '0;
`endif
          idx <= '0;
          bus.busy <= 1'b1;
        end
      end else begin
        acc <= acc_next;
        idx <= idx + IDX_W'(LANES);
        sp <= sp >> LANES;
        sw <= sw >> (LANES * W);
        if (last) begin
          bus.input_current <= hi ? OUT_W'(MAX) : lo ? OUT_W'(MIN) : acc_next[OUT_W-1:0];
          bus.saturated <= hi | lo;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// tb_synaptic_current_accumulator: directed checks of latency, sums, clamping, start filtering and mid-run reset
module tb_synaptic_current_accumulator;
  localparam int M = 24, W = 8, LANES = 4, OUT_W = 8;
  logic clk = 0, reset = 1;
  int vec = 0, err = 0;
  synaptic_current_accumulator_if #(.M(M), .W(W), .OUT_W(OUT_W)) bus();
  synaptic_current_accumulator #(.M(M), .W(W), .LANES(LANES), .OUT_W(OUT_W)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [M*W-1:0] fill(input logic [W-1:0] v);
    logic [M*W-1:0] r;
    for (int i = 0; i < M; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [M*W-1:0] mixed_w();
    logic [M*W-1:0] r;
    r = fill(8'h7F);
    r[0 +: 8] = 8'd10;
    r[8 +: 8] = 8'd20;
    r[40 +: 8] = 8'hFB;
    return r;
  endfunction

  task automatic run_op(input logic [M-1:0] s, input logic [M*W-1:0] w, output int lat, output int bc);
    bus.input_spikes = s;
    bus.weights = w;
    bus.start = 1;
    tick;
    bus.start = 0;
    lat = 0;
    bc = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      tick;
      lat++;
      if (bus.busy) bc++;
    end
  endtask

  task automatic test_reset;
    bus.start = 0;
    bus.input_spikes = '0;
    bus.weights = '0;
`ifdef SYN_BIAS_EN
    bus.bias = '0;
`endif
    reset = 1;
    tick;
    tick;
    vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vec++; if (bus.done !== 1'b0) begin err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vec++; if (bus.input_current !== 8'h00) begin err++; $display("FAIL reset_current: got %h expected 00", bus.input_current); end
    vec++; if (bus.saturated !== 1'b0) begin err++; $display("FAIL reset_sat: got %b expected 0", bus.saturated); end
    reset = 0;
    tick;
  endtask

  task automatic test_zero;
    int lat, bc;
    run_op('0, fill(8'h5A), lat, bc);
    vec++; if (lat != 6) begin err++; $display("FAIL zero_latency: got %0d expected 6", lat); end
    vec++; if (bc != 6) begin err++; $display("FAIL zero_busy_cycles: got %0d expected 6", bc); end
    vec++; if (bus.input_current !== 8'h00) begin err++; $display("FAIL zero_current: got %h expected 00", bus.input_current); end
    vec++; if (bus.saturated !== 1'b0) begin err++; $display("FAIL zero_sat: got %b expected 0", bus.saturated); end
    tick;
    vec++; if (bus.done !== 1'b0) begin err++; $display("FAIL done_width: got %b expected 0", bus.done); end
  endtask

  task automatic test_mixed;
    int lat, bc;
    run_op(24'h000023, mixed_w(), lat, bc);
    vec++; if (lat != 6) begin err++; $display("FAIL mixed_latency: got %0d expected 6", lat); end
    vec++; if (bus.input_current !== 8'h19) begin err++; $display("FAIL mixed_current: got %h expected 19", bus.input_current); end
    vec++; if (bus.saturated !== 1'b0) begin err++; $display("FAIL mixed_sat: got %b expected 0", bus.saturated); end
    tick;
  endtask

  task automatic test_saturate;
    int lat, bc;
    run_op('1, fill(8'd100), lat, bc);
    vec++; if (bus.input_current !== 8'h7F) begin err++; $display("FAIL sat_pos_current: got %h expected 7f", bus.input_current); end
    vec++; if (bus.saturated !== 1'b1) begin err++; $display("FAIL sat_pos_flag: got %b expected 1", bus.saturated); end
    tick;
    run_op('1, fill(8'h80), lat, bc);
    vec++; if (bus.input_current !== 8'h80) begin err++; $display("FAIL sat_neg_current: got %h expected 80", bus.input_current); end
    vec++; if (bus.saturated !== 1'b1) begin err++; $display("FAIL sat_neg_flag: got %b expected 1", bus.saturated); end
    tick;
  endtask

  task automatic test_back_to_back;
    int lat, gap;
    bus.input_spikes = 24'h000023;
    bus.weights = mixed_w();
    bus.start = 1;
    tick;
    lat = 0;
    while (!bus.done && lat < 20) begin
      bus.start = ~bus.start;
      bus.input_spikes = '1;
      bus.weights = fill(8'd3);
      tick;
      lat++;
    end
    vec++; if (lat != 6) begin err++; $display("FAIL b2b_latency: got %0d expected 6", lat); end
    vec++; if (bus.input_current !== 8'h19) begin err++; $display("FAIL b2b_first_current: got %h expected 19", bus.input_current); end
    bus.start = 1;
    tick;
    bus.start = 0;
    gap = 1;
    while (!bus.done && gap < 20) begin
      tick;
      gap++;
    end
    vec++; if (gap != 7) begin err++; $display("FAIL b2b_gap: got %0d expected 7", gap); end
    vec++; if (bus.input_current !== 8'h48) begin err++; $display("FAIL b2b_second_current: got %h expected 48", bus.input_current); end
    vec++; if (bus.saturated !== 1'b0) begin err++; $display("FAIL b2b_second_sat: got %b expected 0", bus.saturated); end
    tick;
  endtask

  task automatic test_reset_mid;
    int lat, bc, dones;
    run_op('1, fill(8'd100), lat, bc);
    vec++; if (bus.input_current !== 8'h7F) begin err++; $display("FAIL pre_reset_current: got %h expected 7f", bus.input_current); end
    tick;
    bus.input_spikes = 24'h000023;
    bus.weights = mixed_w();
    bus.start = 1;
    tick;
    bus.start = 0;
    tick;
    tick;
    tick;
    reset = 1;
    #1;
    vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    vec++; if (bus.input_current !== 8'h00) begin err++; $display("FAIL midreset_current: got %h expected 00", bus.input_current); end
    vec++; if (bus.saturated !== 1'b0) begin err++; $display("FAIL midreset_sat: got %b expected 0", bus.saturated); end
    tick;
    reset = 0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (bus.done) dones++;
    end
    vec++; if (dones != 0) begin err++; $display("FAIL midreset_done: got %0d pulses expected 0", dones); end
    run_op(24'h000023, mixed_w(), lat, bc);
    vec++; if (lat != 6) begin err++; $display("FAIL post_reset_latency: got %0d expected 6", lat); end
    vec++; if (bus.input_current !== 8'h19) begin err++; $display("FAIL post_reset_current: got %h expected 19", bus.input_current); end
    tick;
  endtask

`ifdef SYN_BIAS_EN
  task automatic test_bias;
    int lat, bc;
    logic [M*W-1:0] w;
    w = '0;
    w[16 +: 8] = 8'd50;
    w[24 +: 8] = 8'd40;
    bus.bias = 8'hE2;
    run_op(24'h00000C, w, lat, bc);
    vec++; if (bus.input_current !== 8'h3C) begin err++; $display("FAIL bias_neg_current: got %h expected 3c", bus.input_current); end
    vec++; if (bus.saturated !== 1'b0) begin err++; $display("FAIL bias_neg_sat: got %b expected 0", bus.saturated); end
    tick;
    w = '0;
    w[0 +: 8] = 8'd1;
    bus.bias = 8'h7F;
    run_op(24'h000001, w, lat, bc);
    vec++; if (bus.input_current !== 8'h7F) begin err++; $display("FAIL bias_clamp_current: got %h expected 7f", bus.input_current); end
    vec++; if (bus.saturated !== 1'b1) begin err++; $display("FAIL bias_clamp_sat: got %b expected 1", bus.saturated); end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_zero;
    test_mixed;
    test_saturate;
    test_back_to_back;
    test_reset_mid;
`ifdef SYN_BIAS_EN
    test_bias;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
